isr_feeder: RTL and testbench
=============================

# isr_feeder

Upstream sequencer for the ISR integer-square-root core. It accepts a stream of 64-bit operands on a valid/ready interface and buffers them in a small FIFO. For each operand it drives ISR's load/start (`reset`) and `value` inputs, waits for `done`, and returns operand plus root on a valid/ready output interface. Sustained ISR throughput therefore needs no handshaking logic in the datapath that uses it.

## Interface

- `FIFO_DEPTH`, default 4: operand FIFO entries. Power of two, ≥2.
- `clock`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  operand offered.
- `in_value`  in  64  operand.
- `in_ready`  out  1  FIFO can accept; equals `count < FIFO_DEPTH`.
- `isr_start`  out  1  to ISR `reset`; high loads ISR, low lets it compute.
- `isr_value`  out  64  to ISR `value`; stable from LOAD until leaving WAIT.
- `isr_result`  in  32  from ISR `result`.
- `isr_done`  in  1  from ISR `done`; level, stays high until next load.
- `out_valid`  out  1  result available.
- `out_value`  out  64  operand that produced `out_result`.
- `out_result`  out  32  floor(sqrt(`out_value`)).
- `out_err`  out  1  checker flag (see Configuration).
- `out_ready`  in  1  consumer accepts.
- `count`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- `busy`  out  1  high when FSM ≠ IDLE or `count` ≠ 0.

## Operation

- FIFO: circular buffer with wrapping read/write pointers and `count`.
  - Push when `in_valid && in_ready`.
  - Pop only on the IDLE→LOAD transition.
  - Push and pop in the same cycle leave `count` unchanged.
  - `in_ready` depends on registered `count` only. There is no same-cycle pass-through when full.
- FSM states: IDLE, LOAD, WAIT, HOLD.
  - IDLE: `isr_start`=1, which holds ISR in load. If `count`≠0, pop the head into `isr_value`, go to LOAD.
  - LOAD: `isr_start`=1 for exactly one cycle with the new `isr_value`. Go to WAIT; clear `guard`.
  - WAIT: `isr_start`=0.
    - The first WAIT cycle is a guard cycle. `guard` sets and `isr_done` is ignored, which masks a stale `done`.
    - After that, `isr_done`=1 at an edge captures `isr_result`→`out_result` and `isr_value`→`out_value`, sets `out_valid`, and goes to HOLD.
  - HOLD: `isr_start`=1; `out_*` held stable. On `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- There is no timeout. WAIT persists until `isr_done` qualifies.
- Arithmetic applies to the checker only: 64-bit products of 32-bit operands; `(r+1)^2` computed in 65 bits.

## Timing

- Reset values:
  - `in_ready`=1, `count`=0, `busy`=0.
  - `isr_start`=1, `isr_value`=0.
  - `out_valid`=0, `out_value`=0, `out_result`=0, `out_err`=0.
  - FSM=IDLE, pointers 0.
- Push at edge N into an empty FIFO while IDLE gives:
  - LOAD from N+1: `isr_value` valid, `isr_start`=1.
  - WAIT from N+2: `isr_start` low.
  - Earliest `isr_done` capture at N+4. `out_valid` is high from N+4 at the earliest.
- Output handshake at edge P gives IDLE at P; the next operand reaches LOAD at P+1.
- Full FIFO: `in_ready`=0. An offered operand is neither lost nor duplicated; `in_value` is ignored when `in_ready`=0.
- `out_ready` held low: HOLD persists and the FIFO keeps filling up to `FIFO_DEPTH`.
- Asynchronous reset mid-computation: the in-flight operand and FIFO contents are discarded. `isr_start` goes high immediately, which reloads ISR.

## Configuration

- `ISR_FEEDER_CHECK_EN`, defined: on capture, `out_err` is set if NOT (`r*r ≤ v` AND (`(r+1)^2 > v` OR `r`==32'hFFFF_FFFF)).
  - `r` is `isr_result`; `v` is `isr_value`.
  - `out_err` is registered alongside `out_result` and valid only with `out_valid`.
- Undefined: the checker logic is absent and `out_err` is tied to 0.

## Test plan

- Single operand 64'h1001; ISR `done` after 40 cycles → `out_result`=32'h40, `out_value`=64'h1001, `out_err`=0, `isr_start` low for exactly the WAIT cycles.
- Back-to-back 64'h2345, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0 with `out_ready`=1 → results 32'h5F, 32'hFFFF_FFFF, 32'h0, in order, none dropped.
- `out_ready`=0, push 6 operands with `FIFO_DEPTH`=4:
  - 1 in HOLD plus 4 queued; `count`=4, `in_ready`=0.
  - The 6th operand is held by the source until space frees.
  - Release `out_ready` → all 6 results emitted in order.
- Stale `done`: ISR model keeps `done`=1 through LOAD and the first WAIT cycle, then clears it before recomputing → no capture in the guard cycle; correct result captured later.
- Assert `reset` during WAIT with 2 operands queued → `count`=0, `out_valid`=0, `isr_start`=1 immediately; after release, no output until a new push.
- With `ISR_FEEDER_CHECK_EN`, ISR model returns 32'h41 for 64'h1001 → `out_err`=1; without the macro → `out_err`=0.

Source files
------------

// File: rtl/isr_feeder_if.sv
// isr_feeder_if: bundles the operand stream, the ISR core connection, the
// result stream and the status outputs of isr_feeder.
//
// Handshake rule for both streams (in_* and out_*): a word moves on a rising
// clock edge where valid and ready are both high. The source holds valid and
// its data stable until that edge. The sink may raise or lower ready at any
// time, and ready never depends combinationally on valid.
//
// Modports:
//   master - the feeder itself: drives in_ready, isr_start/isr_value, out_*,
//            count, busy and dbg_state.
//   slave  - the environment: drives in_valid/in_value, isr_result/isr_done,
//            out_ready.
// Signals:
//   in_valid/in_value/in_ready        operand stream (64-bit operands)
//   isr_start/isr_value               to ISR reset/value
//   isr_result/isr_done               from ISR result/done (done is a level)
//   out_valid/out_value/out_result    result stream; out_err checker flag
//   out_ready                         consumer accepts
//   count, busy                       FIFO occupancy and activity
//   dbg_state                         sequencer state (0 idle,1 load,2 wait,3 hold)
interface isr_feeder_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          in_valid;
    logic [63:0]   in_value;
    logic          in_ready;
    logic          isr_start;
    logic [63:0]   isr_value;
    logic [31:0]   isr_result;
    logic          isr_done;
    logic          out_valid;
    logic [63:0]   out_value;
    logic [31:0]   out_result;
    logic          out_err;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          busy;
    logic [1:0]    dbg_state;

    modport master (
        input  in_valid, in_value, isr_result, isr_done, out_ready,
        output in_ready, isr_start, isr_value, out_valid, out_value,
               out_result, out_err, count, busy, dbg_state
    );

    modport slave (
        output in_valid, in_value, isr_result, isr_done, out_ready,
        input  in_ready, isr_start, isr_value, out_valid, out_value,
               out_result, out_err, count, busy, dbg_state
    );
endinterface

// File: rtl/isr_feeder.sv
// isr_feeder: sequencer in front of the ISR integer-square-root core.
// Operands are buffered in a FIFO_DEPTH-entry circular FIFO. Each one is
// loaded into ISR (isr_start high), ISR is released to compute (isr_start
// low), the level `done` is awaited, and operand plus root are offered on the
// output stream.
//
// Ports: clock, reset (asynchronous, active-high) and `bus`, an
// isr_feeder_if.master carrying both streams, the ISR connection and status.
//
// Optional build macro: ISR_FEEDER_CHECK_EN - when defined, each captured root
// is checked (r*r <= v and ((r+1)^2 > v or r == all-ones)) and out_err is
// raised alongside out_result on failure. When undefined out_err is 0.
module isr_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    isr_feeder_if.master bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [63:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [63:0]   r_isr_value;
    logic [63:0]   r_out_value;
    logic [31:0]   r_out_result;
    logic          r_out_valid;
    logic          r_guard;
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_capture;
    logic          w_out_fire;
    logic          w_isr_start;

    // in_ready comes from the registered count only, so a full FIFO never
    // accepts in the cycle it is popped.
    assign w_in_ready = (r_count < CW'(FIFO_DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    // r_guard is low during the first WAIT cycle, so a `done` left over from
    // the previous operand cannot be captured.
    assign w_capture  = (r_state == S_WAIT) && r_guard && bus.isr_done;
    assign w_out_fire = r_out_valid && bus.out_ready;

    // Operand FIFO
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.in_value;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sequencer next state and ISR control
    always_comb begin
        w_next      = r_state;
        w_isr_start = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                w_isr_start = 1'b0;
                if (w_capture) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_out_fire) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand register, guard flag and result capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_isr_value  <= '0;
            r_guard      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_value  <= '0;
            r_out_result <= '0;
        end else begin
            if (w_pop) begin
                r_isr_value <= r_mem[r_rd_ptr];
            end
            if (r_state == S_LOAD) begin
                r_guard <= 1'b0;
            end else if (r_state == S_WAIT) begin
                r_guard <= 1'b1;
            end
            if (w_capture) begin
                r_out_value  <= r_isr_value;
                r_out_result <= bus.isr_result;
                r_out_valid  <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef ISR_FEEDER_CHECK_EN
    logic [63:0] w_sq;
    logic [64:0] w_rp1;
    logic [64:0] w_sq1;
    logic        w_err;
    logic        r_err;

    // (r+1)^2 reaches 2^64 for r = all-ones, hence the 65-bit path.
    always_comb begin
        w_sq  = {32'd0, bus.isr_result} * {32'd0, bus.isr_result};
        w_rp1 = {33'd0, bus.isr_result} + 65'd1;
        w_sq1 = w_rp1 * w_rp1;
        w_err = !((w_sq <= r_isr_value) &&
                  ((w_sq1 > {1'b0, r_isr_value}) || (bus.isr_result == 32'hFFFF_FFFF)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_capture) begin
            r_err <= w_err;
        end
    end

    assign bus.out_err = r_err;
`else
    assign bus.out_err = 1'b0;
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.isr_start  = w_isr_start;
    assign bus.isr_value  = r_isr_value;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_value  = r_out_value;
    assign bus.out_result = r_out_result;
    assign bus.count      = r_count;
    assign bus.busy       = (r_state != S_IDLE) || (r_count != '0);
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_isr_feeder.sv
// tb_isr_feeder: self-checking bench for isr_feeder. A behavioural ISR core
// answers with floor(sqrt) after a configurable latency; a scoreboard keeps
// every accepted operand in order and checks each emitted result against
// a binary-search square root.
module tb_isr_feeder;
    localparam int FIFO_DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    isr_feeder_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    isr_feeder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int low_cnt  = 0;
    logic [63:0] exp_q[$];

    // ISR model controls
    int   lat_cfg    = 0;
    bit   rand_lat   = 1'b0;
    bit   stale_mode = 1'b0;
    bit   bad_mode   = 1'b0;
    logic [63:0] m_val   = '0;
    int          m_cnt   = 0;
    logic        m_done  = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_res   = '0;

    assign bus.isr_result = m_res;
    assign bus.isr_done   = m_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_sqrt(input logic [63:0] v);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 64'hFFFF_FFFF;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        return lo[31:0];
    endfunction

    // Behavioural ISR: high isr_start loads; low lets it count down and then
    // raise a level `done` with the root. In stale mode `done` survives the
    // load and the first compute cycle.
    always @(posedge clock) begin
        if (bus.isr_start) begin
            m_val   <= bus.isr_value;
            m_cnt   <= rand_lat ? int'($urandom_range(0, 6)) : lat_cfg;
            if (!stale_mode) m_done <= 1'b0;
            m_stale <= stale_mode;
        end else if (m_stale) begin
            m_done  <= 1'b0;
            m_stale <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end else if (!m_done) begin
            m_done <= 1'b1;
            m_res  <= bad_mode ? 32'h41 : ref_sqrt(m_val);
        end
    end

    // Scoreboard: inputs change at posedge+1, so values seen at the negedge
    // are exactly those the next rising edge acts on.
    always @(negedge clock) begin
        logic [63:0] v;
        logic [31:0] exp_r;
        logic        exp_e;
        if (!reset) begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_value);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_output", 64'(bus.out_value), 64'hX);
                end else begin
                    v     = exp_q.pop_front();
                    exp_r = bad_mode ? 32'h41 : ref_sqrt(v);
`ifdef ISR_FEEDER_CHECK_EN
                    exp_e = (exp_r != ref_sqrt(v));
`else
                    exp_e = 1'b0;
`endif
                    check("sb_value", bus.out_value, v);
                    check("sb_result", 64'(bus.out_result), 64'(exp_r));
                    check("sb_err", 64'(bus.out_err), 64'(exp_e));
                    n_out++;
                end
            end
            if (!bus.isr_start) low_cnt++;
        end
    end

    // Call at posedge+1; returns at posedge+1 after the operand was taken.
    task automatic push(input logic [63:0] v);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        while (!bus.in_ready && t < 400) begin
            @(posedge clock); #1;
            t++;
        end
        check("push_timeout", 64'(t >= 400), 64'd0);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.in_value = $urandom();
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.busy || bus.out_valid) && t < 3000) begin
            @(posedge clock); #1;
            t++;
        end
        check("drain_timeout", 64'(t >= 3000), 64'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int out_before;
        bit stop_rdy;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        cycles(3);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_isr_start", 64'(bus.isr_start), 64'd1);
        check("rst_isr_value", bus.isr_value, 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_value", bus.out_value, 64'd0);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_out_err", 64'(bus.out_err), 64'd0);
        reset = 1'b0;
        cycles(2);

        // Single operand, done 40 cycles after release
        lat_cfg = 38;
        low_cnt = 0;
        bus.in_valid = 1'b1;
        bus.in_value = 64'h1001;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("t1_latency", 64'(cyc), 64'd42);
        check("t1_out_result", 64'(bus.out_result), 64'h40);
        check("t1_out_value", bus.out_value, 64'h1001);
        check("t1_out_err", 64'(bus.out_err), 64'd0);
        drain();
        check("t1_start_low_cycles", 64'(low_cnt), 64'd40);

        // Earliest capture: four edges after the push
        lat_cfg = 0;
        bus.in_valid = 1'b1;
        bus.in_value = 64'd99;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("t1b_min_latency", 64'(cyc), 64'd4);
        drain();

        // Back-to-back operands
        lat_cfg = 3;
        out_before = n_out;
        push(64'h2345);
        push(64'hFFFF_FFFF_FFFF_FFFF);
        push(64'h0);
        drain();
        check("t2_outputs", 64'(n_out - out_before), 64'd3);

        // Consumer stalled: FIFO fills, sixth operand waits at the source
        lat_cfg = 2;
        bus.out_ready = 1'b0;
        out_before = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) push({$urandom(), $urandom()});
            end
            begin
                cycles(40);
                check("t3_count_full", 64'(bus.count), 64'(FIFO_DEPTH));
                check("t3_in_ready", 64'(bus.in_ready), 64'd0);
                check("t3_hold_state", 64'(bus.dbg_state), 64'd3);
                check("t3_out_valid", 64'(bus.out_valid), 64'd1);
                check("t3_busy", 64'(bus.busy), 64'd1);
                check("t3_accepted", 64'(exp_q.size()), 64'd5);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("t3_outputs", 64'(n_out - out_before), 64'd6);

        // Stale done across load and guard cycle
        stale_mode = 1'b1;
        lat_cfg = 1;
        out_before = n_out;
        push(64'h9);
        drain();
        push(64'h1001);
        drain();
        stale_mode = 1'b0;
        cycles(2);
        check("t4_outputs", 64'(n_out - out_before), 64'd2);

        // Randomized stream with random latency and random consumer stalls
        rand_lat = 1'b1;
        stop_rdy = 1'b0;
        out_before = n_out;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [63:0] v;
                    case ($urandom_range(0, 3))
                        0:       v = 64'($urandom_range(0, 300));
                        1:       v = {32'd0, $urandom()};
                        default: v = {$urandom(), $urandom()};
                    endcase
                    push(v);
                    cycles($urandom_range(0, 3));
                end
                drain();
                stop_rdy = 1'b1;
            end
            begin
                while (!stop_rdy) begin
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    cycles(1);
                end
                bus.out_ready = 1'b1;
            end
        join
        check("t5_outputs", 64'(n_out - out_before), 64'd24);
        rand_lat = 1'b0;

        // Asynchronous reset while computing with two operands queued
        lat_cfg = 30;
        out_before = n_out;
        push(64'd1000);
        push(64'd2000);
        push(64'd3000);
        cyc = 0;
        while (!(bus.dbg_state == 2'd2 && bus.count == 2) && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("t6_reach_wait", 64'(cyc >= 50), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_count", 64'(bus.count), 64'd0);
        check("t6_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_isr_start", 64'(bus.isr_start), 64'd1);
        check("t6_busy", 64'(bus.busy), 64'd0);
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        cycles(60);
        check("t6_no_output", 64'(n_out - out_before), 64'd0);
        check("t6_idle_valid", 64'(bus.out_valid), 64'd0);
        check("t6_idle_busy", 64'(bus.busy), 64'd0);
        check("t6_in_ready", 64'(bus.in_ready), 64'd1);

        // Wrong root from ISR: flagged only when the checker is built in
        lat_cfg = 2;
        bad_mode = 1'b1;
        out_before = n_out;
        push(64'h1001);
        drain();
        cycles(2);
        bad_mode = 1'b0;
        check("t7_outputs", 64'(n_out - out_before), 64'd1);

        // Follow-up operand after the bad one is clean again
        push(64'd144);
        drain();
        cycles(2);

        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
